// File: rtl/fetch_unit.sv
// fetch_unit: program-counter / fetch sequencer for the instruction ROM.
// ProgCtr is the ROM address. The PC advances sequentially, or takes an absolute
// or PC-relative branch, and it honours stall and halt requests. Start/Done form
// the handshake with the test harness. InstCount counts PC advances since the
// last Start and saturates at its maximum value.
module fetch_unit #(
   parameter int              PC_W       = 10,
   parameter int              OFF_W      = 8,
   parameter int              CNT_W      = 16,
   parameter logic [PC_W-1:0] START_ADDR = {PC_W{1'b0}}
) (
   input  logic              Clk,
   input  logic              Reset,
   input  logic              Start,
   input  logic              Stall,
   input  logic              HaltReq,
   input  logic              BranchEn,
   input  logic              BranchRel,
   input  logic [PC_W-1:0]   BranchTarget,
   input  logic [OFF_W-1:0]  BranchOffset,
   output logic [PC_W-1:0]   ProgCtr,
   output logic              Running,
   output logic              Done,
   output logic [CNT_W-1:0]  InstCount
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_RUN    = 2'd1,
      S_HALTED = 2'd2
   } state_t;

   state_t           r_state;
   logic [PC_W-1:0]  r_pc;
   logic [CNT_W-1:0] r_cnt;

   state_t           w_state_nx;
   logic [PC_W-1:0]  w_pc_nx;
   logic [CNT_W-1:0] w_cnt_nx;
   logic [PC_W-1:0]  w_off_ext;
   logic [CNT_W-1:0] w_cnt_inc;

   // The relative offset is sign-extended to PC width. The addition then wraps modulo 2^PC_W.
   assign w_off_ext = {{(PC_W-OFF_W){BranchOffset[OFF_W-1]}}, BranchOffset};

   // The fetch counter sticks at all-ones instead of wrapping.
   assign w_cnt_inc = (r_cnt == {CNT_W{1'b1}}) ? r_cnt
                                               : r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};

   // Next-state, next-PC and next-count selection. In RUN the priority is halt > stall > branch > sequential.
   always_comb begin
      w_state_nx = r_state;
      w_pc_nx    = r_pc;
      w_cnt_nx   = r_cnt;
      case (r_state)
         S_IDLE, S_HALTED: begin
            // Start beats a simultaneous HaltReq here, because a halt only means something in RUN.
            if (Start) begin
               w_state_nx = S_RUN;
               w_pc_nx    = START_ADDR;
               w_cnt_nx   = {CNT_W{1'b0}};
            end else begin
               w_state_nx = r_state;
               w_pc_nx    = r_pc;
               w_cnt_nx   = r_cnt;
            end
         end
         S_RUN: begin
            if (HaltReq) begin
               w_state_nx = S_HALTED;
            end else if (Stall) begin
               // A branch presented during a stall is dropped. The source must hold it.
               w_pc_nx  = r_pc;
               w_cnt_nx = r_cnt;
            end else if (BranchEn) begin
               if (BranchRel) begin
                  w_pc_nx = r_pc + w_off_ext;
               end else begin
                  w_pc_nx = BranchTarget;
               end
               w_cnt_nx = w_cnt_inc;
            end else begin
               w_pc_nx  = r_pc + {{(PC_W-1){1'b0}}, 1'b1};
               w_cnt_nx = w_cnt_inc;
            end
         end
         default: begin
            w_state_nx = S_IDLE;
            w_pc_nx    = {PC_W{1'b0}};
            w_cnt_nx   = {CNT_W{1'b0}};
         end
      endcase
   end

   // State, PC and counter registers. An asynchronous reset returns them all to idle values.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         r_state <= S_IDLE;
         r_pc    <= {PC_W{1'b0}};
         r_cnt   <= {CNT_W{1'b0}};
      end else begin
         r_state <= w_state_nx;
         r_pc    <= w_pc_nx;
         r_cnt   <= w_cnt_nx;
      end
   end

   assign ProgCtr   = r_pc;
   assign InstCount = r_cnt;
   assign Running   = (r_state == S_RUN);
   assign Done      = (r_state == S_HALTED);

endmodule

// File: tb/tb_fetch_unit.sv
// Testbench for fetch_unit. It applies a table of directed per-cycle vectors,
// followed by hand-written sequences for the reset, mid-run reset and
// counter-saturation cases.
module tb_fetch_unit;

   logic        Clk;
   logic        Reset;
   logic        Start, Stall, HaltReq, BranchEn, BranchRel;
   logic [9:0]  BranchTarget;
   logic [7:0]  BranchOffset;
   logic [9:0]  ProgCtr;
   logic        Running, Done;
   logic [15:0] InstCount;

   int n_vec;
   int n_err;

   fetch_unit dut (
      .Clk         (Clk),
      .Reset       (Reset),
      .Start       (Start),
      .Stall       (Stall),
      .HaltReq     (HaltReq),
      .BranchEn    (BranchEn),
      .BranchRel   (BranchRel),
      .BranchTarget(BranchTarget),
      .BranchOffset(BranchOffset),
      .ProgCtr     (ProgCtr),
      .Running     (Running),
      .Done        (Done),
      .InstCount   (InstCount)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   typedef struct {
      logic        start, stall, halt, br_en, br_rel;
      logic [9:0]  tgt;
      logic [7:0]  off;
      logic [9:0]  e_pc;
      logic        e_run, e_done;
      logic [15:0] e_cnt;
   } vec_t;

   localparam int NV = 32;
   vec_t tbl [NV];

   function automatic vec_t mk(input logic st, input logic sl, input logic hr,
                               input logic be, input logic br,
                               input logic [9:0] tg, input logic [7:0] of,
                               input logic [9:0] pc, input logic ru, input logic dn,
                               input logic [15:0] ct);
      vec_t v;
      v.start = st; v.stall = sl; v.halt = hr; v.br_en = be; v.br_rel = br;
      v.tgt = tg; v.off = of; v.e_pc = pc; v.e_run = ru; v.e_done = dn; v.e_cnt = ct;
      return v;
   endfunction

   task automatic check(input string name, input logic [9:0] pc, input logic ru,
                        input logic dn, input logic [15:0] ct);
      n_vec++;
      if (ProgCtr !== pc || Running !== ru || Done !== dn || InstCount !== ct) begin
         n_err++;
         $display("FAIL %s: got pc=%0d run=%b done=%b cnt=%0d, want pc=%0d run=%b done=%b cnt=%0d",
                  name, ProgCtr, Running, Done, InstCount, pc, ru, dn, ct);
      end
   endtask

   task automatic drive(input logic st, input logic sl, input logic hr, input logic be,
                        input logic br, input logic [9:0] tg, input logic [7:0] of);
      Start = st; Stall = sl; HaltReq = hr; BranchEn = be; BranchRel = br;
      BranchTarget = tg; BranchOffset = of;
   endtask

   task automatic tick();
      @(posedge Clk);
      #1;
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 8'd0);

      //                 st    sl    hr    be    br    tgt      off      pc        run   done  cnt
      tbl[0]  = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   8'h00, 10'd0,    1'b1, 1'b0, 16'd0);
      tbl[1]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   8'h00, 10'd1,    1'b1, 1'b0, 16'd1);
      tbl[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   8'h00, 10'd2,    1'b1, 1'b0, 16'd2);
      tbl[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   8'h00, 10'd3,    1'b1, 1'b0, 16'd3);
      tbl[4]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd50,  8'h00, 10'd50,   1'b1, 1'b0, 16'd4);
      tbl[5]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd100, 8'h00, 10'd100,  1'b1, 1'b0, 16'd5);
      tbl[6]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd60,  8'h00, 10'd60,   1'b1, 1'b0, 16'd6);
      tbl[7]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd999, 8'hF6, 10'd50,   1'b1, 1'b0, 16'd7);
      tbl[8]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd2,   8'h00, 10'd2,    1'b1, 1'b0, 16'd8);
      tbl[9]  = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd0,   8'hFC, 10'd1022, 1'b1, 1'b0, 16'd9);
      tbl[10] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   8'h00, 10'd1023, 1'b1, 1'b0, 16'd10);
      tbl[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   8'h00, 10'd0,    1'b1, 1'b0, 16'd11);
      tbl[12] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd5,   8'h00, 10'd5,    1'b1, 1'b0, 16'd12);
      tbl[13] = mk(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd100, 8'h00, 10'd5,    1'b1, 1'b0, 16'd12);
      tbl[14] = mk(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 10'd0,   8'h00, 10'd5,    1'b1, 1'b0, 16'd12);
      tbl[15] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   8'h00, 10'd6,    1'b1, 1'b0, 16'd13);
      tbl[16] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd4,   8'h00, 10'd4,    1'b1, 1'b0, 16'd14);
      tbl[17] = mk(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 10'd100, 8'h00, 10'd4,    1'b0, 1'b1, 16'd14);
      for (int i = 18; i < 28; i++) begin
         tbl[i] = mk(1'b0, i[0], 1'b0, 1'b1, i[1], 10'd100, 8'h10, 10'd4, 1'b0, 1'b1, 16'd14);
      end
      tbl[28] = mk(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0,   8'h00, 10'd0,    1'b1, 1'b0, 16'd0);
      tbl[29] = mk(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd0,   8'h7F, 10'd127,  1'b1, 1'b0, 16'd1);
      tbl[30] = mk(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 10'd0,   8'h00, 10'd127,  1'b0, 1'b1, 16'd1);
      tbl[31] = mk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0,   8'h00, 10'd0,    1'b1, 1'b0, 16'd0);

      // Apply reset, then check the reset values.
      Reset = 1'b0;
      #12;
      check("reset", 10'd0, 1'b0, 1'b0, 16'd0);
      Reset = 1'b1;
      @(negedge Clk);

      // In IDLE, Stall and BranchEn must have no effect.
      drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 10'd100, 8'h00);
      tick();
      check("idle_ignore", 10'd0, 1'b0, 1'b0, 16'd0);

      // Apply the table of per-cycle vectors.
      for (int i = 0; i < NV; i++) begin
         drive(tbl[i].start, tbl[i].stall, tbl[i].halt, tbl[i].br_en, tbl[i].br_rel,
               tbl[i].tgt, tbl[i].off);
         tick();
         check($sformatf("vec%0d", i), tbl[i].e_pc, tbl[i].e_run, tbl[i].e_done, tbl[i].e_cnt);
      end

      // Pulse Reset low mid-run at PC=37. The outputs must clear at once, before any edge.
      drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 10'd37, 8'h00);
      tick();
      check("pc37", 10'd37, 1'b1, 1'b0, 16'd1);
      drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 8'h00);
      #2;
      Reset = 1'b0;
      #1;
      check("async_rst", 10'd0, 1'b0, 1'b0, 16'd0);
      tick();
      Reset = 1'b1;
      tick();
      check("post_rst_idle", 10'd0, 1'b0, 1'b0, 16'd0);

      // Counter saturation. 65540 sequential advances leave PC=65540 mod 1024=4 and the count pinned at 65535.
      drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 10'd0, 8'h00);
      tick();
      check("start2", 10'd0, 1'b1, 1'b0, 16'd0);
      Start = 1'b0;
      for (int i = 0; i < 65540; i++) begin
         tick();
      end
      check("saturate", 10'd4, 1'b1, 1'b0, 16'hFFFF);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
